byte_striping_cond: RTL and testbench

//  Transmit-side byte striper: splits one byte stream into two lanes, even-index bytes to lane 0
//  and odd-index bytes to lane 1. It is the inverse of the two-lane un-striper, which always

---
 rtl/byte_striping_cond.sv | 125 ++++++++++++
 tb/tb_byte_striping_cond.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_striping_cond.sv
// byte_striping_cond: transmit-side two-lane byte striper (clk_2f domain).
// Even-index bytes of a burst go to lane 0 and odd-index bytes to lane 1; every
// burst restarts on lane 0. A saturating counter reports the accepted bytes.
// Optional feature macro: STRIPE_PAD_EN -- when defined, an odd-length burst is
// closed with PAD_BYTE on lane 1 so both lanes carry equal byte counts.
module byte_striping_cond #(
    parameter int unsigned           DATA_WIDTH = 8,
    parameter int unsigned           CNT_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0] PAD_BYTE   = 8'hBC
) (
    input  logic                  clk_2f,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] lane_0,
    output logic                  valid_0,
    output logic [DATA_WIDTH-1:0] lane_1,
    output logic                  valid_1,
    output logic [CNT_WIDTH-1:0]  bytes_striped,
    output logic                  active
);

    typedef enum logic [1:0] {
        ESPERANDO_ENTRADA,
        STRIPE_LANE_1,
        STRIPE_LANE_0
    } state_t;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] lane0_q;
    logic [DATA_WIDTH-1:0] lane1_q;
    logic                  valid0_q;
    logic                  valid1_q;
    logic                  active_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [CNT_WIDTH-1:0]  cnt_d;

`ifndef STRIPE_PAD_EN
    // The filler byte only matters when padding is built in.
    logic pad_unused;
    assign pad_unused = ^PAD_BYTE;
`endif

    // Saturating byte counter: counts accepted input bytes, holds at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (valid_in && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Striping FSM with registered lane outputs; the lane not written holds its value.
    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            state_q  <= ESPERANDO_ENTRADA;
            lane0_q  <= '0;
            lane1_q  <= '0;
            valid0_q <= 1'b0;
            valid1_q <= 1'b0;
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_d;
            case (state_q)
                ESPERANDO_ENTRADA: begin
                    if (valid_in) begin
                        lane0_q  <= data_in;
                        valid0_q <= 1'b1;
                        state_q  <= STRIPE_LANE_1;
                        active_q <= 1'b1;
                    end else begin
                        lane0_q  <= '0;
                        lane1_q  <= '0;
                        valid0_q <= 1'b0;
                        valid1_q <= 1'b0;
                        active_q <= 1'b0;
                    end
                end
                STRIPE_LANE_1: begin
                    if (valid_in) begin
                        lane1_q  <= data_in;
                        valid1_q <= 1'b1;
                        state_q  <= STRIPE_LANE_0;
                        active_q <= 1'b1;
                    end else begin
`ifdef STRIPE_PAD_EN
                        lane1_q  <= PAD_BYTE;
                        valid1_q <= 1'b1;
`else
                        lane1_q  <= '0;
                        valid1_q <= 1'b0;
`endif
                        state_q  <= ESPERANDO_ENTRADA;
                        active_q <= 1'b0;
                    end
                end
                STRIPE_LANE_0: begin
                    if (valid_in) begin
                        lane0_q  <= data_in;
                        valid0_q <= 1'b1;
                        state_q  <= STRIPE_LANE_1;
                        active_q <= 1'b1;
                    end else begin
                        lane0_q  <= '0;
                        valid0_q <= 1'b0;
                        state_q  <= ESPERANDO_ENTRADA;
                        active_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ESPERANDO_ENTRADA;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign lane_0        = lane0_q;
    assign valid_0       = valid0_q;
    assign lane_1        = lane1_q;
    assign valid_1       = valid1_q;
    assign bytes_striped = cnt_q;
    assign active        = active_q;

endmodule

// File: tb/tb_byte_striping_cond.sv
// Testbench for byte_striping_cond. Two instances share the stimulus: the
// default configuration and one with a 4-bit counter for saturation checks.
module tb_byte_striping_cond;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = '0;
    logic       vin = 1'b0;

    logic [7:0]  l0_a, l1_a, l0_b, l1_b;
    logic        v0_a, v1_a, act_a, v0_b, v1_b, act_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    always #5 clk = ~clk;

    byte_striping_cond #(.DATA_WIDTH(8), .CNT_WIDTH(16), .PAD_BYTE(8'hBC)) dut_a (
        .clk_2f(clk), .reset(rst), .data_in(din), .valid_in(vin),
        .lane_0(l0_a), .valid_0(v0_a), .lane_1(l1_a), .valid_1(v1_a),
        .bytes_striped(cnt_a), .active(act_a)
    );

    byte_striping_cond #(.DATA_WIDTH(8), .CNT_WIDTH(4), .PAD_BYTE(8'hBC)) dut_b (
        .clk_2f(clk), .reset(rst), .data_in(din), .valid_in(vin),
        .lane_0(l0_b), .valid_0(v0_b), .lane_1(l1_b), .valid_1(v1_b),
        .bytes_striped(cnt_b), .active(act_b)
    );

    logic [34:0] obs_a;
    logic [22:0] obs_b;
    assign obs_a = {l0_a, v0_a, l1_a, v1_a, act_a, cnt_a};
    assign obs_b = {l0_b, v0_b, l1_b, v1_b, act_b, cnt_b};

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: position within the current burst decides the lane.
    logic [7:0] m_l0, m_l1;
    logic       m_v0, m_v1, m_prev_v;
    int         m_idx;   // bytes accepted so far in the current burst
    int         m_total; // bytes accepted since reset (unbounded)

    task automatic model_reset();
        m_l0 = '0; m_l1 = '0; m_v0 = 1'b0; m_v1 = 1'b0;
        m_prev_v = 1'b0; m_idx = 0; m_total = 0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d);
        if (v) begin
            if (m_idx % 2 == 0) begin m_l0 = d; m_v0 = 1'b1; end
            else                begin m_l1 = d; m_v1 = 1'b1; end
            m_idx++;
            m_total++;
        end else if (m_prev_v) begin
            // Burst just ended: the lane that would have taken the next byte closes.
            if (m_idx % 2 == 0) begin
                m_l0 = '0; m_v0 = 1'b0;
            end else begin
`ifdef STRIPE_PAD_EN
                m_l1 = 8'hBC; m_v1 = 1'b1;
`else
                m_l1 = '0; m_v1 = 1'b0;
`endif
            end
            m_idx = 0;
        end else begin
            m_l0 = '0; m_l1 = '0; m_v0 = 1'b0; m_v1 = 1'b0;
            m_idx = 0;
        end
        m_prev_v = v;
    endtask

    function automatic logic [34:0] exp_a();
        logic [15:0] c;
        c = (m_total > 65535) ? 16'hFFFF : 16'(m_total);
        return {m_l0, m_v0, m_l1, m_v1, m_prev_v, c};
    endfunction

    function automatic logic [22:0] exp_b();
        logic [3:0] c;
        c = (m_total > 15) ? 4'hF : 4'(m_total);
        return {m_l0, m_v0, m_l1, m_v1, m_prev_v, c};
    endfunction

    // Drive one cycle of input, then advance the model past the clock edge.
    task automatic step(input logic v, input logic [7:0] d);
        din = d;
        vin = v;
        @(posedge clk);
        #1;
        model_step(v, d);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        vin = 1'b0;
        din = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        vin = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (obs_a !== '0) begin
            n_fail++;
            $display("FAIL reset_a: got %h expected %h", obs_a, 35'h0);
        end
        n_checks++;
        if (obs_b !== '0) begin
            n_fail++;
            $display("FAIL reset_b: got %h expected %h", obs_b, 23'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_even_burst();
        logic [7:0] bytes [4];
        bytes = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i < 4) step(1'b1, bytes[i]);
            else       step(1'b0, 8'h00);
            n_checks++;
            if (obs_a !== exp_a()) begin
                n_fail++;
                $display("FAIL even_burst c%0d: got %h expected %h", i + 1, obs_a, exp_a());
            end
            if (i == 3) begin
                n_checks++;
                if ({l0_a, l1_a, v0_a, v1_a} !== {8'hA3, 8'hA4, 1'b1, 1'b1}) begin
                    n_fail++;
                    $display("FAIL even_lanes_c4: got %h/%h expected a3/a4", l0_a, l1_a);
                end
            end
            if (i == 4) begin
                n_checks++;
                if (v0_a !== 1'b0 || v1_a !== 1'b1) begin
                    n_fail++;
                    $display("FAIL even_valids_c5: got %b%b expected 01", v0_a, v1_a);
                end
            end
        end
        n_checks++;
        if (v1_a !== 1'b0 || cnt_a !== 16'd4) begin
            n_fail++;
            $display("FAIL even_end: got valid_1=%b cnt=%0d expected 0/4", v1_a, cnt_a);
        end
    endtask

    task automatic test_odd_burst();
        logic [7:0] bytes [3];
        bytes = '{8'hB1, 8'hB2, 8'hB3};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i < 3) step(1'b1, bytes[i]);
            else       step(1'b0, 8'h00);
            n_checks++;
            if (obs_a !== exp_a()) begin
                n_fail++;
                $display("FAIL odd_burst c%0d: got %h expected %h", i + 1, obs_a, exp_a());
            end
            if (i == 2) begin
                n_checks++;
                if (l0_a !== 8'hB3 || v0_a !== 1'b1) begin
                    n_fail++;
                    $display("FAIL odd_lane0_c3: got %h expected b3", l0_a);
                end
            end
            if (i == 3) begin
                n_checks++;
`ifdef STRIPE_PAD_EN
                if (l1_a !== 8'hBC || v1_a !== 1'b1) begin
                    n_fail++;
                    $display("FAIL odd_pad_c4: got %h/%b expected bc/1", l1_a, v1_a);
                end
`else
                if (l1_a !== 8'h00 || v1_a !== 1'b0) begin
                    n_fail++;
                    $display("FAIL odd_nopad_c4: got %h/%b expected 00/0", l1_a, v1_a);
                end
`endif
            end
        end
        n_checks++;
        if (v0_a !== 1'b0 || v1_a !== 1'b0 || cnt_a !== 16'd3) begin
            n_fail++;
            $display("FAIL odd_end: got v0=%b v1=%b cnt=%0d expected 0/0/3", v0_a, v1_a, cnt_a);
        end
    endtask

    task automatic test_gap_restart();
        logic [7:0] bytes [7];
        logic       vals  [7];
        bytes = '{8'hC1, 8'hC2, 8'hC3, 8'h55, 8'hC4, 8'hC5, 8'h00};
        vals  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(vals[i], bytes[i]);
            n_checks++;
            if (obs_a !== exp_a()) begin
                n_fail++;
                $display("FAIL gap c%0d: got %h expected %h", i + 1, obs_a, exp_a());
            end
            if (i == 4) begin
                n_checks++;
                if (l0_a !== 8'hC4 || v0_a !== 1'b1) begin
                    n_fail++;
                    $display("FAIL gap_restart_lane0: got %h expected c4", l0_a);
                end
            end
            if (i == 5) begin
                n_checks++;
                if (l1_a !== 8'hC5 || v1_a !== 1'b1) begin
                    n_fail++;
                    $display("FAIL gap_restart_lane1: got %h expected c5", l1_a);
                end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        step(1'b1, 8'hD1);
        step(1'b1, 8'hD2);
        #3;
        rst = 1'b1;
        vin = 1'b0;
        din = '0;
        #1;
        model_reset();
        n_checks++;
        if (obs_a !== '0 || obs_b !== '0) begin
            n_fail++;
            $display("FAIL async_reset_clear: got %h/%h expected 0", obs_a, obs_b);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (obs_a !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: got %h expected 0", obs_a);
        end
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 8'hE1);
        n_checks++;
        if (l0_a !== 8'hE1 || v0_a !== 1'b1 || v1_a !== 1'b0 || cnt_a !== 16'd1) begin
            n_fail++;
            $display("FAIL after_reset_e1: got l0=%h v0=%b v1=%b cnt=%0d expected e1/1/0/1",
                     l0_a, v0_a, v1_a, cnt_a);
        end
        n_checks++;
        if (obs_a !== exp_a()) begin
            n_fail++;
            $display("FAIL after_reset_model: got %h expected %h", obs_a, exp_a());
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'(8'h10 + i));
            n_checks++;
            if (obs_b !== exp_b()) begin
                n_fail++;
                $display("FAIL sat c%0d: got %h expected %h", i + 1, obs_b, exp_b());
            end
        end
        n_checks++;
        if (cnt_b !== 4'hF || cnt_a !== 16'd20) begin
            n_fail++;
            $display("FAIL sat_end: got %h/%0d expected f/20", cnt_b, cnt_a);
        end
        n_checks++;
        if (l0_b !== 8'h22 || l1_b !== 8'h23) begin
            n_fail++;
            $display("FAIL sat_lanes: got %h/%h expected 22/23", l0_b, l1_b);
        end
        step(1'b0, 8'h00);
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 6, 8'($urandom));
            n_checks++;
            if (obs_a !== exp_a()) begin
                n_fail++;
                $display("FAIL random_a c%0d: got %h expected %h", i, obs_a, exp_a());
            end
            n_checks++;
            if (obs_b !== exp_b()) begin
                n_fail++;
                $display("FAIL random_b c%0d: got %h expected %h", i, obs_b, exp_b());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_even_burst();
        test_odd_burst();
        test_gap_restart();
        test_reset_mid_burst();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
